// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the MEM-stage data bus controller.
// No logic, so no latency or backpressure.
package mem_bus_ctrl_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// Pipeline-request and data-bus signal bundle of mem_bus_ctrl; master = controller side.
// Wires only: no latency; the slave modport applies backpressure through bus_ack.
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 32
);
  import mem_bus_ctrl_pkg::*;

  logic              req_valid;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              stall;
  logic [DATA_W-1:0] rdata;
  logic              rdata_valid;

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [3:0]        bus_be;
  logic              bus_ack;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_err;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, req_be, bus_ack, bus_rdata,
    output stall, rdata, rdata_valid,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, req_be, bus_ack, bus_rdata,
    input  stall, rdata, rdata_valid,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );

endinterface

// File: rtl/mem_bus_ctrl_timeout_cnt.sv
// Counts enabled cycles since clear; expired is high in the enabled cycle whose count reaches limit.
// Expiry is combinational on the current count; no backpressure.
module bus_timeout_cnt (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= 8'd0;
    else if (clear)  cnt <= 8'd0;
    else if (enable) cnt <= cnt + 8'd1;
  end

  // Widened compare so limit = 255 never wraps.
  assign expired = enable && (({1'b0, cnt} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/mem_bus_ctrl.sv
// MEM-stage load/store to req/ack bus bridge; k-cycle slave gives k+2 cycles, stalls pipeline until done.
// Optional abort on a silent slave when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255,
  parameter int         ADDR_W         = 32
) (
  input  logic           clk,
  input  logic           reset,
  mem_bus_ctrl_if.master bus
);

  state_t            state, state_nxt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] rdata_q;
  logic              busy;
  logic              timeout;

  assign busy = (state == BUSY);

`ifdef MEM_BUS_TIMEOUT_EN
  logic err_q;

  bus_timeout_cnt u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (!busy),
    .enable  (busy && !bus.bus_ack),
    .limit   (TIMEOUT_CYCLES),
    .expired (timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= busy && timeout;
  end

  assign bus.bus_err = err_q;
`else
  assign timeout     = 1'b0;
  assign bus.bus_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          // A store touching no lanes completes without a bus cycle.
          if (bus.req_we && (bus.req_be == BE_NONE)) state_nxt = DONE;
          else                                       state_nxt = BUSY;
        end
      end
      BUSY:    if (bus.bus_ack || timeout) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= BE_NONE;
    end else if ((state == IDLE) && bus.req_valid) begin
      lat_we    <= bus.req_we;
      lat_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
      lat_wdata <= bus.req_wdata;
      lat_be    <= bus.req_be;
    end
  end

  // Ack has priority over a coincident timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (busy) begin
      if (bus.bus_ack) begin
        if (!lat_we) rdata_q <= bus.bus_rdata;
      end else if (timeout) begin
        rdata_q <= '0;
      end
    end
  end

  assign bus.bus_req     = busy;
  assign bus.bus_we      = busy && lat_we;
  assign bus.bus_addr    = busy ? lat_addr  : '0;
  assign bus.bus_wdata   = busy ? lat_wdata : '0;
  assign bus.bus_be      = busy ? lat_be    : BE_NONE;
  assign bus.stall       = ((state == IDLE) && bus.req_valid) || busy;
  assign bus.rdata       = rdata_q;
  assign bus.rdata_valid = (state == DONE);

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed plus randomized load/store transactions checked against a per-transaction timing/data model.
`timescale 1ns/1ps
module tb_mem_bus_ctrl;

  localparam logic [7:0] TO = 8'd4;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_bus_ctrl_if #(.ADDR_W(32)) bif ();

  mem_bus_ctrl #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  int          tests = 0;
  int          fails = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one pipeline request and plays a slave that acks on busy cycle k (k = 0: never).
  // Returns in the cycle after the completion pulse, so the next call is back-to-back.
  task automatic do_txn(input string name, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input int k,
                        input logic [31:0] ack_data);
    bit          no_bus, timed_out, done;
    int          exp_busy, cycles, busy, stalls;
    logic [31:0] exp_rdata;

    no_bus    = we && (be == 4'b0000);
    timed_out = !no_bus && TO_EN && ((k == 0) || (k > int'(TO)));
    exp_busy  = no_bus ? 0 : (timed_out ? int'(TO) : k);
    if (timed_out)            exp_rdata = 32'h0;
    else if (!we && !no_bus)  exp_rdata = ack_data;
    else                      exp_rdata = model_rdata;

    bif.req_valid = 1'b1;
    bif.req_we    = we;
    bif.req_addr  = addr;
    bif.req_wdata = wdata;
    bif.req_be    = be;
    #1;
    cycles = 0; busy = 0; stalls = 0; done = 1'b0;
    while (!done && cycles < 300) begin
      cycles++;
      if (bif.stall) stalls++;
      if (bif.bus_req) begin
        busy++;
        if (busy == 1 || busy == exp_busy) begin
          check({name, ".bus_addr"}, bif.bus_addr, addr & 32'hFFFF_FFFC);
          check({name, ".bus_we"},   32'(bif.bus_we), 32'(we));
          check({name, ".bus_be"},   32'(bif.bus_be), 32'(be));
          if (we) check({name, ".bus_wdata"}, bif.bus_wdata, wdata);
        end
        if (busy == k) begin
          bif.bus_ack   = 1'b1;
          bif.bus_rdata = ack_data;
        end else begin
          bif.bus_ack   = 1'b0;
          bif.bus_rdata = $urandom;
        end
      end else begin
        // Spurious acks outside a bus cycle must be ignored.
        bif.bus_ack   = 1'($urandom_range(0, 1));
        bif.bus_rdata = $urandom;
      end
      if (bif.rdata_valid) begin
        done = 1'b1;
        check({name, ".latency"},   32'(cycles), 32'(exp_busy + 2));
        check({name, ".stall_cyc"}, 32'(stalls), 32'(exp_busy + 1));
        check({name, ".busy_cyc"},  32'(busy),   32'(exp_busy));
        check({name, ".done_stall"}, 32'(bif.stall), 32'h0);
        check({name, ".rdata"},     bif.rdata, exp_rdata);
        check({name, ".bus_err"},   32'(bif.bus_err), 32'(timed_out));
      end
      @(negedge clk);
      #1;
    end
    check({name, ".completed"}, 32'(done), 32'h1);
    model_rdata = exp_rdata;
    bif.bus_ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          we;
    logic [3:0]  be;
    bif.req_valid = 1'b0;
    bif.req_we    = 1'b0;
    bif.req_addr  = 32'h0;
    bif.req_wdata = 32'h0;
    bif.req_be    = 4'h0;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = 32'h0;

    repeat (2) @(negedge clk);
    #1;
    check("rst.bus_req",     32'(bif.bus_req), 32'h0);
    check("rst.bus_we",      32'(bif.bus_we), 32'h0);
    check("rst.bus_addr",    bif.bus_addr, 32'h0);
    check("rst.bus_wdata",   bif.bus_wdata, 32'h0);
    check("rst.bus_be",      32'(bif.bus_be), 32'h0);
    check("rst.rdata",       bif.rdata, 32'h0);
    check("rst.rdata_valid", 32'(bif.rdata_valid), 32'h0);
    check("rst.bus_err",     32'(bif.bus_err), 32'h0);
    check("rst.stall",       32'(bif.stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    do_txn("sw_word", 1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 1, $urandom);
    do_txn("lw_slow", 1'b0, 32'h0000_200B, $urandom, 4'b1111, 4, 32'h1234_5678);
    do_txn("sw_be0",  1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'b0000, 1, $urandom);

    // Reset while the slave is still thinking.
    bif.req_valid = 1'b1; bif.req_we = 1'b0; bif.req_addr = 32'h0000_3000; bif.req_be = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mid.bus_req_before", 32'(bif.bus_req), 32'h1);
    reset = 1'b1;
    #1;
    check("mid.bus_req_dropped", 32'(bif.bus_req), 32'h0);
    check("mid.bus_addr",        bif.bus_addr, 32'h0);
    bif.req_valid = 1'b0;
    #1;
    check("mid.stall_idle",      32'(bif.stall), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    bif.bus_ack = 1'b1; bif.bus_rdata = 32'h0BAD_0BAD;
    model_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("mid.late_ack_req",   32'(bif.bus_req), 32'h0);
      check("mid.late_ack_valid", 32'(bif.rdata_valid), 32'h0);
    end
    check("mid.rdata_cleared", bif.rdata, 32'h0);
    bif.bus_ack = 1'b0;
    @(negedge clk);

    do_txn("sb_lane1", 1'b1, 32'h0000_0101, 32'h0000_AB00, 4'b0010, 2, $urandom);
    do_txn("sb_lane3", 1'b1, 32'h0000_0103, 32'hCD00_0000, 4'b1000, 1, $urandom);

`ifdef MEM_BUS_TIMEOUT_EN
    do_txn("lw_timeout",  1'b0, 32'h0000_4000, $urandom, 4'b1111, 0, $urandom);
    do_txn("lw_ack_wins", 1'b0, 32'h0000_4004, $urandom, 4'b1111, int'(TO), 32'h5A5A_A5A5);
`endif

    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      if ($urandom_range(0, 3) == 0) be = 4'b0000;
      if ($urandom_range(0, 2) == 0) begin
        bif.req_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      do_txn("rand", we, $urandom, $urandom, be, int'($urandom_range(1, 6)), $urandom);
    end

    bif.req_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
